// File: rtl/term_cmd_decoder.sv
// term_cmd_decoder: assembles UART bytes into a line and decodes it into a held one-hot op_code
module term_cmd_decoder #(
    parameter int          MAX_LEN = 8,
    parameter logic [7:0]  CR_CODE = 8'h0D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [10:0] op_code,
    output logic        cmd_valid,
    output logic        cmd_err,
    output logic        busy
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);
    // Command text is left-aligned in 40 bits: character j sits at bits [39-8j -: 8]
    localparam logic [10:0][39:0] CMD_TXT = {
        {"rgb", 16'h0}, {"echo", 8'h0}, {"beep", 8'h0}, {"time", 8'h0},
        {"help", 8'h0}, {"stop", 8'h0}, "siren", {"cnt", 16'h0},
        {"seg", 16'h0}, {"led", 16'h0}, {"clr", 16'h0}
    };
    localparam int CMD_LEN [11] = '{3, 3, 3, 3, 5, 4, 4, 4, 4, 4, 3};

    typedef enum logic [1:0] {COLLECT, COMPARE, UPDATE} state_t;

    state_t       state;
    logic [LW-1:0] len_q;
    logic          ovf_q;
    logic [7:0]    buf_q [MAX_LEN];
    logic [10:0]   match;
    logic [10:0]   match_q;
    logic [7:0]    ch;
    logic          is_bs;

    assign ch    = (rx_data >= 8'h41 && rx_data <= 8'h5A) ? rx_data + 8'h20 : rx_data;
    assign is_bs = (rx_data == 8'h08) || (rx_data == 8'h7F);

    // Full-length match of the buffered line against every command entry
    always_comb begin
        match = '0;
        for (int i = 0; i < 11; i++) begin
            match[i] = (int'(len_q) == CMD_LEN[i]);
            for (int j = 0; j < 5; j++)
                if (j < CMD_LEN[i] && buf_q[j] != CMD_TXT[i][39-8*j -: 8])
                    match[i] = 1'b0;
        end
    end

    // Line collection, compare/update sequencing and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            match_q   <= '0;
            op_code   <= '0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++)
                buf_q[i] <= '0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            case (state)
                COLLECT: begin
                    if (rx_valid) begin
                        if (rx_data == CR_CODE) begin
                            if (len_q != '0 || ovf_q) begin
                                state <= COMPARE;
                                busy  <= 1'b1;
                            end
                        end else if (rx_data != 8'h0A) begin
                            if (is_bs)
                                len_q <= (len_q != '0) ? len_q - LW'(1) : len_q;
                            else if (len_q == LW'(MAX_LEN))
                                ovf_q <= 1'b1;
                            else begin
                                buf_q[len_q[IW-1:0]] <= ch;
                                len_q <= len_q + LW'(1);
                            end
                        end
                    end
                end
                COMPARE: begin
                    match_q <= match;
                    state   <= UPDATE;
                end
                UPDATE: begin
                    op_code   <= (|match_q && !ovf_q) ? match_q : '0;
                    cmd_valid <= |match_q && !ovf_q;
                    cmd_err   <= !(|match_q && !ovf_q);
                    len_q     <= '0;
                    ovf_q     <= 1'b0;
                    busy      <= 1'b0;
                    state     <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_term_cmd_decoder.sv
// tb_term_cmd_decoder: randomized line stimulus checked against a queue-based reference model
module tb_term_cmd_decoder;
    localparam int MAX_LEN = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [10:0] op_code;
    logic        cmd_valid, cmd_err, busy;

    int checks = 0;
    int failures = 0;

    byte unsigned line_q[$];
    bit           ovf = 1'b0;
    logic [10:0]  exp_op = '0;
    string        cmds [11] = '{"clr", "led", "seg", "cnt", "siren", "stop",
                                "help", "time", "beep", "echo", "rgb"};

    term_cmd_decoder #(.MAX_LEN(MAX_LEN), .CR_CODE(8'h0D)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .op_code(op_code), .cmd_valid(cmd_valid), .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Index of the command the model line spells, or -1
    function automatic int lookup();
        for (int k = 0; k < 11; k++) begin
            if (cmds[k].len() == line_q.size()) begin
                bit same = 1'b1;
                for (int j = 0; j < line_q.size(); j++)
                    if (cmds[k][j] != line_q[j]) same = 1'b0;
                if (same) return k;
            end
        end
        return -1;
    endfunction

    // Send one byte; on a terminating CR, verify the busy window and the result pulse
    task automatic send(input logic [7:0] b, input bit drop = 1'b0);
        logic [10:0] prev;
        int k;
        rx_data = b;
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        if (b == 8'h0D) begin
            if (line_q.size() > 0 || ovf) begin
                prev = exp_op;
                k = lookup();
                check("busy_after_cr", 32'(busy), 1);
                check("no_early_pulse", {cmd_valid, cmd_err}, 0);
                if (drop) begin
                    rx_data = 8'h78;
                    rx_valid = 1'b1;
                end
                cyc();
                rx_valid = 1'b0;
                check("busy_compare", 32'(busy), 1);
                check("op_held_compare", op_code, prev);
                exp_op = (k >= 0 && !ovf) ? 11'(1 << k) : '0;
                cyc();
                check("op_code", op_code, exp_op);
                check("cmd_valid", 32'(cmd_valid), (k >= 0 && !ovf) ? 1 : 0);
                check("cmd_err", 32'(cmd_err), (k >= 0 && !ovf) ? 0 : 1);
                check("busy_done", 32'(busy), 0);
                cyc();
                check("pulse_width", {cmd_valid, cmd_err}, 0);
                check("op_hold", op_code, exp_op);
                line_q.delete();
                ovf = 1'b0;
            end else begin
                cyc();
                check("empty_cr_quiet", {busy, cmd_valid, cmd_err}, 0);
                check("empty_cr_op", op_code, exp_op);
            end
        end else if (b == 8'h0A) begin
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (line_q.size() > 0) void'(line_q.pop_back());
        end else begin
            byte unsigned c = (b >= "A" && b <= "Z") ? byte'(b + 8'h20) : byte'(b);
            if (line_q.size() < MAX_LEN) line_q.push_back(c);
            else ovf = 1'b1;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic pulse_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_outputs", {op_code, cmd_valid, cmd_err, busy}, 0);
        cyc();
        rst = 1'b0;
        line_q.delete();
        ovf = 1'b0;
        exp_op = '0;
        cyc();
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 9))
            0: return 8'h08;
            1: return 8'h7F;
            2: return 8'h0A;
            3: return 8'(8'h30 + $urandom_range(0, 9));
            4, 5: return 8'(8'h41 + $urandom_range(0, 25));
            default: return 8'(8'h61 + $urandom_range(0, 25));
        endcase
    endfunction

    initial begin
        #2;
        check("init_rst", {op_code, cmd_valid, cmd_err, busy}, 0);
        #10;
        rst = 1'b0;
        cyc();
        pulse_reset();
        send_str("siren");
        send(8'h0D);
        check("siren_const", op_code, 11'h010);
        send_str("SIRXX");
        send(8'h08);
        send(8'h08);
        send_str("EN");
        send(8'h0D);
        check("fold_bs_const", op_code, 11'h010);
        send_str("LED");
        send(8'h0D);
        check("led_const", op_code, 11'h002);
        send_str("siren");
        send(8'h0D);
        send_str("sire");
        send(8'h0D);
        check("prefix_const", op_code, 11'h000);
        send_str("sirens");
        send(8'h0D);
        send_str("abcdefghi");
        send(8'h0D);
        send_str("rgb");
        send(8'h0D);
        check("rgb_const", op_code, 11'h400);
        send(8'h0D);
        send(8'h0A);
        send(8'h0D);
        send_str("clr");
        send(8'h0D, 1'b1);
        check("clr_const", op_code, 11'h001);
        send(8'h0D);
        send_str("sir");
        pulse_reset();
        send_str("en");
        send(8'h0D);
        check("rst_midline_const", op_code, 11'h000);
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                string s = cmds[$urandom_range(0, 10)];
                for (int i = 0; i < s.len(); i++) begin
                    logic [7:0] c = s[i];
                    if ($urandom_range(0, 3) == 0) c = c - 8'h20;
                    if ($urandom_range(0, 5) == 0) begin
                        send(rand_byte());
                        send(8'h08);
                    end
                    send(c);
                end
                case ($urandom_range(0, 5))
                    0: send(8'h73);
                    1: send(8'h7F);
                    default: ;
                endcase
            end else begin
                int len = $urandom_range(0, 12);
                for (int i = 0; i < len; i++) send(rand_byte());
            end
            if ($urandom_range(0, 3) == 0) cyc();
            send(8'h0D, 1'($urandom_range(0, 1)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
